// File: rtl/io_mmio_ctrl.sv
// MMIO peripheral: 10 LEDs and 12 debounced, change-tracked switches behind a single-outstanding req/ack bus.
// Response one cycle after request; a request arriving while the ack is pending waits for the next IDLE cycle.
module io_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [9:0]  LED_RESET       = 10'h001
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  input  logic [11:0] sw_raw,
  output logic [9:0]  led_o,
  output logic        irq
);

  localparam int          CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_led;
  logic [11:0]   r_sync1, r_sync2, r_sw_stable, r_changed;
  logic          r_irq_en;
  logic [CW-1:0] r_deb_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_acc, w_hit, w_err, w_wr, w_sw_diff, w_deb_fire;
  logic [1:0]    w_off;
  logic [31:0]   w_rdata;
  logic [11:0]   w_set, w_clr;
  logic          w_unused;

  assign w_unused = &{1'b0, bus_addr[1:0], bus_wdata[31:12]};

  // Access decode; read data reflects the pre-write register contents.
  always_comb begin
    w_acc   = (r_state == ST_IDLE) && bus_req;
    w_hit   = (bus_addr[31:4] == BASE_ADDR[31:4]);
    w_off   = bus_addr[3:2];
    w_err   = !w_hit || (bus_we && (w_off == 2'd1));
    w_wr    = w_acc && bus_we && !w_err;
    w_rdata = 32'h0;
    if (!bus_we && !w_err) begin
      case (w_off)
        2'd0:    w_rdata = {22'h0, r_led};
        2'd1:    w_rdata = {20'h0, r_sw_stable};
        2'd2:    w_rdata = {20'h0, r_changed};
        default: w_rdata = {31'h0, r_irq_en};
      endcase
    end
  end

  always_comb begin
    w_sw_diff  = (r_sync2 != r_sw_stable);
    w_deb_fire = w_sw_diff && (r_deb_cnt == CNT_LAST);
    w_set      = w_deb_fire ? (r_sync2 ^ r_sw_stable) : 12'h0;
    w_clr      = (w_wr && (w_off == 2'd2)) ? bus_wdata[11:0] : 12'h0;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus_ack     = 1'b0;
    bus_rdata   = 32'h0;
    bus_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus_req) w_state_nxt = ST_RESP;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        bus_ack     = 1'b1;
        bus_rdata   = r_rdata;
        bus_err     = r_err;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_led    <= LED_RESET;
      r_irq_en <= 1'b0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
      if (w_wr && (w_off == 2'd0)) r_led    <= bus_wdata[9:0];
      if (w_wr && (w_off == 2'd3)) r_irq_en <= bus_wdata[0];
    end
  end

  // A change set by the debouncer on the same edge as a W1C clear takes priority.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_sync1     <= 12'h0;
      r_sync2     <= 12'h0;
      r_sw_stable <= 12'h0;
      r_changed   <= 12'h0;
      r_deb_cnt   <= '0;
    end else begin
      r_sync1   <= sw_raw;
      r_sync2   <= r_sync1;
      r_changed <= (r_changed & ~w_clr) | w_set;
      if (!w_sw_diff || w_deb_fire) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt != CNT_LAST) begin
        r_deb_cnt <= r_deb_cnt + CW'(1);
      end
      if (w_deb_fire) r_sw_stable <= r_sync2;
    end
  end

  assign led_o = r_led;
  assign irq   = r_irq_en & (|r_changed);

endmodule
